// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with a pending-write scoreboard.
//
// Holds 2**AW registers of DW bits. It has NUM_RD combinational read ports
// and one write port with byte-lane enables. When HAS_PC is set, the top
// index is not stored and reads back as r15. When BYPASS is set, a read of
// the address being written returns the post-write value in the same cycle.
// A busy bit per register marks an outstanding write, such as a load in
// flight. busy_cnt holds how many busy bits are set.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   we3, wa3, wd3    write enable, write address, write data
//   wbe              byte-lane write enables (bit k -> wd3[8k+7:8k])
//   ra               packed read addresses, port i = ra[i*AW +: AW]
//   r15              value returned for the PC index
//   rsv_en, rsv_a    reserve: set the busy bit of rsv_a
//   rd               packed read data, port i = rd[i*DW +: DW]
//   rd_busy          busy bit of each port's address
//   busy_cnt         number of busy registers
//
// Handshake: there is no valid/ready flow control. Each write and each
// reserve is a single-cycle command that takes effect at the rising edge
// where its enable (we3 or rsv_en) is high.
module regfile_sb #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int HAS_PC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we3,
  input  logic [AW-1:0]        wa3,
  input  logic [DW-1:0]        wd3,
  input  logic [DW/8-1:0]      wbe,
  input  logic [NUM_RD*AW-1:0] ra,
  input  logic [DW-1:0]        r15,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_a,
  output logic [NUM_RD*DW-1:0] rd,
  output logic [NUM_RD-1:0]    rd_busy,
  output logic [AW:0]          busy_cnt
);

  localparam int            NREG = 1 << AW;
  localparam int            NB   = DW / 8;
  localparam logic [AW-1:0] PC_A = '1;

  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] busy;

  // Byte-lane merge of the write data into an old register value.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] m;
    m = old_v;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) m[8*k +: 8] = new_v[8*k +: 8];
    end
    return m;
  endfunction

  // The PC index is never stored and can never be reserved.
  logic write_ok, rsv_ok, cnt_inc, cnt_dec;

  always_comb begin
    write_ok = we3 && !((HAS_PC != 0) && (wa3 == PC_A));
    rsv_ok   = rsv_en && !((HAS_PC != 0) && (rsv_a == PC_A));
    // A reserve of a register that is already busy leaves it unchanged.
    cnt_inc  = rsv_ok && !busy[rsv_a];
    // A clear counts only when the register is busy now and is not
    // re-reserved in the same cycle, because the new load wins.
    cnt_dec  = write_ok && busy[wa3] && !(rsv_ok && (rsv_a == wa3));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (write_ok) begin
        rf[wa3]   <= merge(rf[wa3], wd3, wbe);
        busy[wa3] <= 1'b0;
      end
      // Placed after the clear so that a reserve wins on a collision.
      if (rsv_ok) busy[rsv_a] <= 1'b1;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] a;
      logic          hit;
      a   = ra[i*AW +: AW];
      hit = (BYPASS != 0) && we3 && (wa3 == a);
      if ((HAS_PC != 0) && (a == PC_A))
        rd[i*DW +: DW] = r15;
      else if (hit)
        rd[i*DW +: DW] = merge(rf[a], wd3, wbe);
      else
        rd[i*DW +: DW] = rf[a];
      // A write this cycle resolves the pending result, so it reads not-busy.
      rd_busy[i] = busy[a] && !hit;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic [3:0]  wbe;
  logic [7:0]  ra;
  logic [31:0] r15;
  logic        rsv_en;
  logic [3:0]  rsv_a;
  logic [63:0] rd, rd_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [4:0]  busy_cnt, busy_cnt_nb;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  // Reference model state
  logic [31:0] m_rf [16];
  logic        m_busy [16];
  int          m_cnt;

  regfile_sb #(.DW(32), .AW(4), .NUM_RD(2), .BYPASS(1), .HAS_PC(1)) dut (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .wbe(wbe),
    .ra(ra), .r15(r15), .rsv_en(rsv_en), .rsv_a(rsv_a),
    .rd(rd), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DW(32), .AW(4), .NUM_RD(2), .BYPASS(0), .HAS_PC(1)) dut_nb (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .wbe(wbe),
    .ra(ra), .r15(r15), .rsv_en(rsv_en), .rsv_a(rsv_a),
    .rd(rd_nb), .rd_busy(rd_busy_nb), .busy_cnt(busy_cnt_nb)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [3:0] a, input bit byp);
    if (a == 4'd15) return r15;
    if (byp && we3 && (wa3 == a)) return model_merge(m_rf[a], wd3, wbe);
    return m_rf[a];
  endfunction

  function automatic logic model_busy(input logic [3:0] a, input bit byp);
    if (a == 4'd15) return 1'b0;
    if (byp && we3 && (wa3 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 16; i++) begin m_rf[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      if (we3 && wa3 != 4'd15) begin
        m_rf[wa3]   = model_merge(m_rf[wa3], wd3, wbe);
        m_busy[wa3] = 1'b0;
      end
      if (rsv_en && rsv_a != 4'd15) m_busy[rsv_a] = 1'b1;
    end
    m_cnt = 0;
    for (int i = 0; i < 16; i++) if (m_busy[i]) m_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; we3 = 1'b0; rsv_en = 1'b0; wbe = 4'h0;
  endtask

  task automatic drive_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    we3 = 1'b1; wa3 = a; wd3 = d; wbe = be;
  endtask

  task automatic drive_rsv(input logic [3:0] a);
    rsv_en = 1'b1; rsv_a = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; we3 = 1'b1; wa3 = 4'd1; wd3 = 32'hFFFF_FFFF; wbe = 4'hF;
    rsv_en = 1'b1; rsv_a = 4'd2; r15 = 32'h0000_1008; ra = '0;
    tick();
    idle();
    for (int a = 0; a < 16; a++) begin
      ra = {4'(15 - a), 4'(a)};
      exp_q.push_back((a == 15) ? 32'h0000_1008 : 32'h0);
      exp_q.push_back((a == 0)  ? 32'h0000_1008 : 32'h0);
      #1;
      e = exp_q.pop_front(); total++;
      if (rd[31:0] !== e) begin bad++; $display("FAIL reset_rd0 a=%0d got=%h exp=%h", a, rd[31:0], e); end
      e = exp_q.pop_front(); total++;
      if (rd[63:32] !== e) begin bad++; $display("FAIL reset_rd1 a=%0d got=%h exp=%h", 15 - a, rd[63:32], e); end
      total++;
      if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_busy a=%0d got=%b exp=00", a, rd_busy); end
    end
    total++;
    if (busy_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_write_mask();
    drive_write(4'd3, 32'hDEAD_BEEF, 4'hF); tick();
    drive_write(4'd3, 32'h0000_00AA, 4'h1); tick();
    idle(); ra = {4'd0, 4'd3};
    exp_q.push_back(32'hDEAD_BEAA);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd_nb[31:0] !== e) begin bad++; $display("FAIL mask_r3 got=%h exp=%h", rd_nb[31:0], e); end
    // wbe=0 write leaves data unchanged
    drive_write(4'd3, 32'h0, 4'h0); tick();
    idle();
    exp_q.push_back(32'hDEAD_BEAA);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd[31:0] !== e) begin bad++; $display("FAIL mask_wbe0 got=%h exp=%h", rd[31:0], e); end
  endtask

  task automatic test_bypass();
    drive_write(4'd5, 32'hAAAA_5555, 4'hF); tick();
    ra = {4'd0, 4'd5};
    drive_write(4'd5, 32'h0000_1234, 4'hF);
    exp_q.push_back(32'h0000_1234); exp_q.push_back(32'hAAAA_5555);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd[31:0] !== e) begin bad++; $display("FAIL bypass_on got=%h exp=%h", rd[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (rd_nb[31:0] !== e) begin bad++; $display("FAIL bypass_off got=%h exp=%h", rd_nb[31:0], e); end
    tick();
    drive_write(4'd5, 32'h0000_5600, 4'b0010);
    exp_q.push_back(32'h0000_5634); exp_q.push_back(32'h0000_1234);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd[31:0] !== e) begin bad++; $display("FAIL bypass_lane got=%h exp=%h", rd[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (rd_nb[31:0] !== e) begin bad++; $display("FAIL bypass_lane_off got=%h exp=%h", rd_nb[31:0], e); end
    tick();
    idle();
    exp_q.push_back(32'h0000_5634);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd_nb[31:0] !== e) begin bad++; $display("FAIL bypass_after got=%h exp=%h", rd_nb[31:0], e); end
  endtask

  task automatic test_scoreboard();
    ra = {4'd0, 4'd7};
    drive_rsv(4'd7); tick();
    idle(); #1;
    total++;
    if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL rsv_busy got=%b exp=1", rd_busy[0]); end
    total++;
    if (busy_cnt !== 5'd1) begin bad++; $display("FAIL rsv_cnt got=%0d exp=1", busy_cnt); end
    drive_rsv(4'd7); tick();
    idle(); #1;
    total++;
    if (busy_cnt !== 5'd1) begin bad++; $display("FAIL rsv_again_cnt got=%0d exp=1", busy_cnt); end
    drive_rsv(4'd7); drive_write(4'd7, 32'h0000_0077, 4'hF); #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL busy_bypass got=%b exp=0", rd_busy[0]); end
    total++;
    if (rd_busy_nb[0] !== 1'b1) begin bad++; $display("FAIL busy_nobypass got=%b exp=1", rd_busy_nb[0]); end
    tick();
    idle(); #1;
    total++;
    if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL rsv_wins_busy got=%b exp=1", rd_busy[0]); end
    total++;
    if (busy_cnt !== 5'd1) begin bad++; $display("FAIL rsv_wins_cnt got=%0d exp=1", busy_cnt); end
    drive_write(4'd7, 32'h0000_0078, 4'hF); tick();
    idle(); #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", rd_busy[0]); end
    total++;
    if (busy_cnt !== 5'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_cross_and_pc();
    drive_rsv(4'd4); tick();
    idle();
    drive_rsv(4'd2); drive_write(4'd4, 32'h4444_4444, 4'hF); tick();
    idle(); ra = {4'd2, 4'd4}; #1;
    total++;
    if (busy_cnt !== 5'd1) begin bad++; $display("FAIL cross_cnt got=%0d exp=1", busy_cnt); end
    total++;
    if (rd_busy !== 2'b10) begin bad++; $display("FAIL cross_busy got=%b exp=10", rd_busy); end
    r15 = 32'h0000_2008;
    drive_write(4'd15, 32'h0000_CAFE, 4'hF); drive_rsv(4'd15); tick();
    idle(); ra = {4'd15, 4'd15};
    exp_q.push_back(32'h0000_2008);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd_nb[63:32] !== e) begin bad++; $display("FAIL pc_read got=%h exp=%h", rd_nb[63:32], e); end
    total++;
    if (busy_cnt !== 5'd1) begin bad++; $display("FAIL pc_rsv_cnt got=%0d exp=1", busy_cnt); end
    total++;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL pc_busy got=%b exp=00", rd_busy); end
    drive_write(4'd2, 32'h2222_2222, 4'hF); tick();
    idle(); #1;
    total++;
    if (busy_cnt !== 5'd0) begin bad++; $display("FAIL cross_clr_cnt got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] a0, a1;
    for (int n = 0; n < 300; n++) begin
      reset  = 1'b0;
      we3    = 1'($urandom_range(0, 1));
      wa3    = 4'($urandom_range(0, 15));
      wd3    = $urandom;
      wbe    = 4'($urandom_range(0, 15));
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_a  = 4'($urandom_range(0, 15));
      r15    = $urandom;
      a0     = 4'($urandom_range(0, 15));
      a1     = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      ra     = {a1, a0};
      exp_q.push_back(model_rd(a0, 1'b1));
      exp_q.push_back(model_rd(a1, 1'b1));
      exp_q.push_back(model_rd(a0, 1'b0));
      #1;
      e = exp_q.pop_front(); total++;
      if (rd[31:0] !== e) begin bad++; $display("FAIL rand_rd0 n=%0d a=%0d got=%h exp=%h", n, a0, rd[31:0], e); end
      e = exp_q.pop_front(); total++;
      if (rd[63:32] !== e) begin bad++; $display("FAIL rand_rd1 n=%0d a=%0d got=%h exp=%h", n, a1, rd[63:32], e); end
      e = exp_q.pop_front(); total++;
      if (rd_nb[31:0] !== e) begin bad++; $display("FAIL rand_nb_rd0 n=%0d a=%0d got=%h exp=%h", n, a0, rd_nb[31:0], e); end
      total++;
      if (rd_busy !== {model_busy(a1, 1'b1), model_busy(a0, 1'b1)}) begin
        bad++; $display("FAIL rand_busy n=%0d got=%b", n, rd_busy);
      end
      total++;
      if (rd_busy_nb[0] !== model_busy(a0, 1'b0)) begin
        bad++; $display("FAIL rand_busy_nb n=%0d got=%b", n, rd_busy_nb[0]);
      end
      total++;
      if (busy_cnt !== 5'(m_cnt)) begin bad++; $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, busy_cnt, m_cnt); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_override();
    reset = 1'b1; drive_write(4'd6, 32'hFFFF_FFFF, 4'hF); drive_rsv(4'd9);
    tick();
    idle(); r15 = 32'h0000_3008;
    for (int a = 0; a < 16; a++) begin
      ra = {4'(a), 4'(a)};
      exp_q.push_back((a == 15) ? 32'h0000_3008 : 32'h0);
      #1;
      e = exp_q.pop_front(); total++;
      if (rd_nb[31:0] !== e) begin bad++; $display("FAIL rst2_rd a=%0d got=%h exp=%h", a, rd_nb[31:0], e); end
      total++;
      if (rd_busy !== 2'b00) begin bad++; $display("FAIL rst2_busy a=%0d got=%b exp=00", a, rd_busy); end
    end
    total++;
    if (busy_cnt !== 5'd0 || busy_cnt_nb !== 5'd0) begin
      bad++; $display("FAIL rst2_cnt got=%0d/%0d exp=0", busy_cnt, busy_cnt_nb);
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    reset = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; wbe = '0;
    ra = '0; r15 = '0; rsv_en = 1'b0; rsv_a = '0;
    @(posedge clk); #1;
    test_reset();
    test_write_mask();
    test_bypass();
    test_scoreboard();
    test_cross_and_pc();
    test_random();
    test_reset_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
